mem_lsu: RTL and testbench
==========================

# mem_lsu

Load/store unit for the MIPS MEM stage, sitting directly upstream of the word-wide data memory (`datamem`). Accepts one load/store request at a time from the pipeline and drives the memory's word read/write ports. Performs byte/halfword extraction with sign/zero extension. Implements sub-word stores as a two-cycle read-modify-write, because the memory writes only full words. Reports misaligned accesses instead of touching memory.

## Interface
Parameters:
- AW, 10, memory word-address width; byte address bits [AW+1:2] select the word.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when req_valid && req_ready.
- req_op  in  3  lsu_op_t: LB, LH, LW, LBU, LHU, SB, SH, SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low byte/halfword used for SB/SH.
- resp_valid  out  1  one-cycle pulse: operation complete.
- resp_rdata  out  32  load result, extended; 0 for stores and faults.
- resp_fault  out  1  access faulted (valid with resp_valid).
- mem_R_addr  out  AW  memory read word address.
- mem_W_addr  out  AW  memory write word address.
- mem_readMem  out  1  memory read enable.
- mem_writeMem  out  1  memory write enable.
- mem_W_data  out  32  memory write data.
- mem_R_data  in  32  memory read data; combinational, same cycle.

## Operation
- FSM states: IDLE and RMW_WR. req_ready = (state == IDLE) && rst.
- Byte lane k = addr[1:0] maps to bits [8k+7:8k], little-endian. Halfword lane = addr[1].
- Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0. These cause no memory strobe and set resp_fault=1. The FSM stays in IDLE.
- Loads, accepted in IDLE:
  - mem_readMem=1 and mem_R_addr=word address in the accept cycle.
  - The extracted, extended value is registered into resp_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- SW, accepted in IDLE: mem_writeMem=1, mem_W_addr=word address, mem_W_data=req_wdata in the accept cycle.
- SB/SH, accepted in IDLE:
  - Cycle 1: mem_readMem=1. The addressed lane is replaced with req_wdata[7:0] or [15:0]; the merged word and the word address are latched; the FSM moves to RMW_WR.
  - Cycle 2 (RMW_WR): mem_writeMem=1 from the latched word and address; req_ready=0; the FSM returns to IDLE.
- When idle or writing, mem_readMem=0 and mem_R_addr holds its last value.

## Timing
- Reset values (rst low, asynchronous): state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, merge/address registers 0. mem_readMem and mem_writeMem are forced 0 while rst is low.
- Latency:
  - Load, SW, and faults: resp_valid exactly 1 cycle after accept.
  - SB/SH: resp_valid 2 cycles after accept, in the cycle after RMW_WR.
- Throughput: one request per cycle for loads/SW; SB/SH block acceptance for the RMW_WR cycle.
- A load accepted the cycle after an SW or RMW_WR write returns the newly written data.
- No backpressure on the response side; resp_valid is never held.
- Reset asserted during RMW_WR aborts the write. No partial write occurs after rst falls.

## Configuration
- LSU_BOUNDS_CHECK_EN defined:
  - An access with req_addr[31:AW+2] ≠ 0 is a fault: no strobe, resp_fault=1, resp_rdata=0, 1-cycle latency.
- Undefined: upper address bits are ignored and the access wraps modulo 2^(AW+2) bytes.

## Structure
- Shared package lsu_pkg: lsu_op_t enum (3-bit), lsu_state_t enum, lane-select constants.
- One combinational sub-module, lsu_align:
  - Load-lane extraction with sign/zero extension.
  - Store-lane merge.
  - Misalignment detection.
- mem_lsu holds the FSM, response registers, and RMW latches.

## Test plan
- Preload word 5 = 0x8899AABB. LB at addr 0x14 → resp_rdata 0xFFFFFFBB. LBU at 0x17 → 0x00000088. LH at 0x16 → 0xFFFF8899.
- SW 0x12345678 at 0x20, then LW at 0x20 on the next cycle → write strobe in the accept cycle; load returns 0x12345678 with 1-cycle latency.
- Word 8 = 0x12345678. SB 0xEE at 0x21 → read strobe in cycle 1, write 0x1234EE78 in cycle 2, req_ready=0 in cycle 2, resp_valid in cycle 3.
- LW at 0x22 and SH at 0x23 → no memory strobe; resp_fault=1, resp_rdata 0; memory unchanged.
- rst asserted during RMW_WR of SH 0xBEEF at 0x24 → no write occurs, outputs return to reset values immediately, and word 9 is unchanged.
- With LSU_BOUNDS_CHECK_EN, LW at 0x00001000 → resp_fault=1. Without it, the same access reads word 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  // Little-endian lane select: byte lane k lives at bits [8k+7:8k].
  localparam int unsigned BYTE_LANE_SHIFT = 3;
  localparam int unsigned HALF_LANE_SHIFT = 4;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_RMW_WR = 1'b1
  } lsu_state_t;

  function automatic logic is_load(input lsu_op_t op);
    return op inside {LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge,
// and misalignment detection.
module lsu_align
  import lsu_pkg::*;
(
  input  lsu_op_t         op_i,
  input  logic [1:0]      lane_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] load_o,
  output logic [XLEN-1:0] merge_o,
  output logic            misalign_o
);

  logic [4:0]        byte_sh;
  logic [4:0]        half_sh;
  logic [BYTE_W-1:0] rbyte;
  logic [HALF_W-1:0] rhalf;
  logic [XLEN-1:0]   lane_mask;
  logic [XLEN-1:0]   lane_data;
  logic              unused_wdata_hi;

  assign byte_sh = {lane_i, 3'b000};
  assign half_sh = {lane_i[1], 4'b0000};
  assign rbyte   = rdata_i[byte_sh +: BYTE_W];
  assign rhalf   = rdata_i[half_sh +: HALF_W];

  // Store data above the halfword only matters for SW, which bypasses the merge.
  assign unused_wdata_hi = ^wdata_i[XLEN-1:HALF_W];

  always_comb begin
    load_o = '0;
    unique case (op_i)
      LSU_LB:  load_o = {{(XLEN-BYTE_W){rbyte[BYTE_W-1]}}, rbyte};
      LSU_LBU: load_o = {{(XLEN-BYTE_W){1'b0}}, rbyte};
      LSU_LH:  load_o = {{(XLEN-HALF_W){rhalf[HALF_W-1]}}, rhalf};
      LSU_LHU: load_o = {{(XLEN-HALF_W){1'b0}}, rhalf};
      LSU_LW:  load_o = rdata_i;
      default: load_o = '0;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    unique case (op_i)
      LSU_SB: begin
        lane_mask = XLEN'({BYTE_W{1'b1}}) << byte_sh;
        lane_data = XLEN'(wdata_i[BYTE_W-1:0]) << byte_sh;
      end
      LSU_SH: begin
        lane_mask = XLEN'({HALF_W{1'b1}}) << half_sh;
        lane_data = XLEN'(wdata_i[HALF_W-1:0]) << half_sh;
      end
      default: begin
        lane_mask = '0;
        lane_data = '0;
      end
    endcase
    merge_o = (rdata_i & ~lane_mask) | lane_data;
  end

  always_comb begin
    misalign_o = 1'b0;
    unique case (op_i)
      LSU_LH, LSU_LHU, LSU_SH: misalign_o = lane_i[0];
      LSU_LW, LSU_SW:          misalign_o = |lane_i;
      default:                 misalign_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit in front of a word-wide data memory; sub-word
// stores use a read-modify-write. Optional feature macro: LSU_BOUNDS_CHECK_EN.
module mem_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned AW = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  lsu_op_t         req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic [AW-1:0]   mem_R_addr,
  output logic [AW-1:0]   mem_W_addr,
  output logic            mem_readMem,
  output logic            mem_writeMem,
  output logic [XLEN-1:0] mem_W_data,
  input  logic [XLEN-1:0] mem_R_data
);

  lsu_state_t      state_q, state_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_fault_q, resp_fault_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic [XLEN-1:0] merge_q, merge_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [AW-1:0]   raddr_q, raddr_d;

  logic            accept;
  logic            misalign;
  logic            out_of_bounds;
  logic            fault;
  logic [AW-1:0]   word_addr;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] merged;
  logic            rd_en, wr_en;
  logic [AW-1:0]   r_addr, w_addr;
  logic [XLEN-1:0] w_data;

  lsu_align u_align (
    .op_i       (req_op),
    .lane_i     (req_addr[1:0]),
    .wdata_i    (req_wdata),
    .rdata_i    (mem_R_data),
    .load_o     (load_val),
    .merge_o    (merged),
    .misalign_o (misalign)
  );

`ifdef LSU_BOUNDS_CHECK_EN
  assign out_of_bounds = |req_addr[XLEN-1:AW+2];
`else
  // Upper address bits are dropped so accesses wrap within the memory.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:AW+2];
  assign out_of_bounds  = 1'b0;
`endif

  assign word_addr = req_addr[AW+1:2];
  assign fault     = misalign | out_of_bounds;
  assign req_ready = (state_q == ST_IDLE) && rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_fault_d = 1'b0;
    resp_rdata_d = '0;
    merge_d      = merge_q;
    waddr_d      = waddr_q;
    raddr_d      = raddr_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;
    r_addr       = raddr_q;
    w_addr       = waddr_q;
    w_data       = merge_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          resp_valid_d = 1'b1;
          if (fault) begin
            resp_fault_d = 1'b1;
          end else if (is_load(req_op)) begin
            rd_en        = 1'b1;
            r_addr       = word_addr;
            raddr_d      = word_addr;
            resp_rdata_d = load_val;
          end else if (req_op == LSU_SW) begin
            wr_en  = 1'b1;
            w_addr = word_addr;
            w_data = req_wdata;
          end else begin
            // Sub-word store: read now, write the merged word next cycle.
            rd_en        = 1'b1;
            r_addr       = word_addr;
            raddr_d      = word_addr;
            merge_d      = merged;
            waddr_d      = word_addr;
            resp_valid_d = 1'b0;
            state_d      = ST_RMW_WR;
          end
        end
      end
      ST_RMW_WR: begin
        wr_en        = 1'b1;
        resp_valid_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      resp_valid_q <= 1'b0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      merge_q      <= '0;
      waddr_q      <= '0;
      raddr_q      <= '0;
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      merge_q      <= merge_d;
      waddr_q      <= waddr_d;
      raddr_q      <= raddr_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_fault   = resp_fault_q;
  assign resp_rdata   = resp_rdata_q;
  assign mem_readMem  = rd_en && rst;
  assign mem_writeMem = wr_en && rst;
  assign mem_R_addr   = r_addr;
  assign mem_W_addr   = w_addr;
  assign mem_W_data   = w_data;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu against a byte-level reference memory model.
module tb_mem_lsu;
  import lsu_pkg::*;

  localparam int unsigned AW     = 10;
  localparam int unsigned NWORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  lsu_op_t       req_op = LSU_LB;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_fault;
  logic [AW-1:0] mem_R_addr;
  logic [AW-1:0] mem_W_addr;
  logic          mem_readMem;
  logic          mem_writeMem;
  logic [31:0]   mem_W_data;
  logic [31:0]   mem_R_data;

  mem_lsu #(.AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_R_addr   (mem_R_addr),
    .mem_W_addr   (mem_W_addr),
    .mem_readMem  (mem_readMem),
    .mem_writeMem (mem_writeMem),
    .mem_W_data   (mem_W_data),
    .mem_R_data   (mem_R_data)
  );

  always #5 clk = ~clk;

  // Physical data memory with a backdoor port for preloading.
  logic [31:0]   phys_mem [NWORDS];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) phys_mem[bd_addr] <= bd_data;
    else if (mem_writeMem) phys_mem[mem_W_addr] <= mem_W_data;
  end
  assign mem_R_data = phys_mem[mem_R_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] ref_mem [NWORDS];

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: sizes, alignment and lanes computed with plain arithmetic.
  function automatic void model(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic flt, output int lat,
                                output logic rd_stb, output logic wr_stb,
                                output int unsigned idx, output logic [31:0] new_word);
    int unsigned size, off;
    logic        is_ld, sgn;
    logic [31:0] m, v;
    size  = (op == LSU_LB || op == LSU_LBU || op == LSU_SB) ? 1 :
            (op == LSU_LH || op == LSU_LHU || op == LSU_SH) ? 2 : 4;
    is_ld = (op == LSU_LB || op == LSU_LH || op == LSU_LW || op == LSU_LBU || op == LSU_LHU);
    sgn   = (op == LSU_LB || op == LSU_LH);
    off   = addr % 4;
    idx   = (addr / 4) % NWORDS;
    flt   = (addr % size) != 0;
`ifdef LSU_BOUNDS_CHECK_EN
    if (addr >= 4 * NWORDS) flt = 1'b1;
`endif
    m        = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
    rd       = '0;
    lat      = 1;
    rd_stb   = 1'b0;
    wr_stb   = 1'b0;
    new_word = ref_mem[idx];
    if (!flt) begin
      if (is_ld) begin
        rd_stb = 1'b1;
        v = (ref_mem[idx] >> (8 * off)) & m;
        if (sgn && v[8 * size - 1]) v = v | ~m;
        rd = v;
      end else begin
        wr_stb   = (size == 4);
        rd_stb   = (size != 4);
        lat      = (size == 4) ? 1 : 2;
        new_word = (ref_mem[idx] & ~(m << (8 * off))) | ((wd & m) << (8 * off));
        ref_mem[idx] = new_word;
      end
    end
  endfunction

  task automatic issue(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] rd, nw;
    logic        flt, rs, ws;
    int          lat, n;
    int unsigned idx;
    exp_t        e;
    model(op, addr, wd, rd, flt, lat, rs, ws, idx, nw);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: req_ready stuck at %b, expected 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    chk("rd_strobe", 32'(mem_readMem), 32'(rs));
    chk("wr_strobe", 32'(mem_writeMem), 32'(ws));
    if (rs) chk("rd_addr", 32'(mem_R_addr), idx);
    if (ws) begin
      chk("wr_addr", 32'(mem_W_addr), idx);
      chk("wr_data", mem_W_data, nw);
    end
    e.rdata = rd;
    e.fault = flt;
    e.cyc   = cyc + lat;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (lat == 2) begin
      @(negedge clk);
      chk("rmw_wr_strobe", 32'(mem_writeMem), 32'd1);
      chk("rmw_rd_strobe", 32'(mem_readMem), 32'd0);
      chk("rmw_wr_addr", 32'(mem_W_addr), idx);
      chk("rmw_wr_data", mem_W_data, nw);
      chk("rmw_ready", 32'(req_ready), 32'd0);
    end
  endtask

  // Response monitor: pops the scoreboard on every resp_valid.
  always @(negedge clk) begin
    exp_t e;
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h, expected no response", resp_rdata);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_fault", 32'(resp_fault), 32'(e.fault));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lsu_op_t     op;
    logic [31:0] a, w9;
    int unsigned sz, diffs;

    // Reset state, with a request pending to show strobes are held off.
    req_valid = 1'b1;
    req_op    = LSU_LW;
    #3;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    chk("rst_readMem", 32'(mem_readMem), 32'd0);
    chk("rst_writeMem", 32'(mem_writeMem), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;

    bd_we = 1'b1;
    for (int i = 0; i < int'(NWORDS); i++) begin
      bd_addr    = AW'(i);
      bd_data    = (i == 5) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = bd_data;
      @(posedge clk);
      #1;
    end
    bd_we = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Directed scenarios.
    issue(LSU_LB,  32'h14, 32'h0);
    issue(LSU_LBU, 32'h17, 32'h0);
    issue(LSU_LH,  32'h16, 32'h0);
    issue(LSU_SW,  32'h20, 32'h1234_5678);
    issue(LSU_LW,  32'h20, 32'h0);
    issue(LSU_SB,  32'h21, 32'h0000_00EE);
    issue(LSU_LW,  32'h20, 32'h0);
    issue(LSU_LW,  32'h22, 32'h0);
    issue(LSU_SH,  32'h23, 32'hBEEF);
    issue(LSU_LW,  32'h1000, 32'h0);
    issue(LSU_SH,  32'h26, 32'hCAFE);
    issue(LSU_LHU, 32'h26, 32'h0);

    // Randomized traffic over a small window so loads observe earlier stores.
    for (int k = 0; k < 400; k++) begin
      op = lsu_op_t'(3'($urandom_range(0, 7)));
      a  = {$urandom_range(0, 31), 2'($urandom_range(0, 3))};
      sz = (op == LSU_LB || op == LSU_LBU || op == LSU_SB) ? 1 :
           (op == LSU_LH || op == LSU_LHU || op == LSU_SH) ? 2 : 4;
      if ($urandom_range(0, 1) == 0) a = a & ~(sz - 1);
      if ($urandom_range(0, 9) == 0) a[31:AW+2] = (32 - AW - 2)'($urandom);
      issue(op, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (5) @(posedge clk);
    #1;

    // Reset during the write cycle of a sub-word store aborts it.
    w9        = ref_mem[9];
    req_valid = 1'b1;
    req_op    = LSU_SH;
    req_addr  = 32'h24;
    req_wdata = 32'hBEEF;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("abort_writeMem", 32'(mem_writeMem), 32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_resp_rdata", resp_rdata, 32'd0);
    chk("abort_ready_low", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_word9", phys_mem[9], w9);
    chk("abort_post_ready", 32'(req_ready), 32'd1);
    issue(LSU_LW, 32'h24, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    diffs = 0;
    for (int i = 0; i < int'(NWORDS); i++)
      if (phys_mem[i] !== ref_mem[i]) diffs++;
    chk("mem_image_diffs", diffs, 32'd0);
    chk("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
